// File: rtl/touch_adc_responder.sv
// rtl/touch_adc_responder.sv - ADS7843-style touch ADC responder: decodes DCLK/CS/DIN commands, drives BUSY/DOUT
module touch_adc_responder (
    input  logic        cclk,
    input  logic        rst,
    input  logic        touch_clk,
    input  logic        touch_csb,
    input  logic        touch_din,
    input  logic [11:0] x_sample,
    input  logic [11:0] y_sample,
    input  logic [11:0] z_sample,
    output logic        touch_busy,
    output logic        touch_dout,
    output logic [7:0]  last_cmd,
    output logic        frame_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_BUSY, ST_DATA} state_t;

    state_t      state_q, state_d;
    logic [2:0]  clk_sync_q, clk_sync_d;
    logic [1:0]  csb_sync_q, csb_sync_d;
    logic [1:0]  din_sync_q, din_sync_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [11:0] shadow_q, shadow_d;
    logic [3:0]  remaining_q, remaining_d;
    logic        busy_phase_q, busy_phase_d;
    logic        busy_q, busy_d;
    logic        dout_q, dout_d;
    logic [7:0]  last_cmd_q, last_cmd_d;
    logic        done_q, done_d;

    logic        rise, fall, csb_s, din_s;
    logic [7:0]  cmd_next;
    logic [11:0] sel_sample;

    // clk_sync_q[1] is the synchronised DCLK, clk_sync_q[2] its previous value
    assign rise  = clk_sync_q[1] & ~clk_sync_q[2];
    assign fall  = ~clk_sync_q[1] & clk_sync_q[2];
    assign csb_s = csb_sync_q[1];
    assign din_s = din_sync_q[1];

    always_comb begin
        clk_sync_d   = {clk_sync_q[1:0], touch_clk};
        csb_sync_d   = {csb_sync_q[0], touch_csb};
        din_sync_d   = {din_sync_q[0], touch_din};
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        shadow_d     = shadow_q;
        remaining_d  = remaining_q;
        busy_phase_d = busy_phase_q;
        busy_d       = busy_q;
        dout_d       = dout_q;
        last_cmd_d   = last_cmd_q;
        done_d       = 1'b0;
        cmd_next     = {shift_q[6:0], din_s};
        case (cmd_next[6:4])
            3'b101:  sel_sample = x_sample;
            3'b001:  sel_sample = y_sample;
            3'b011:  sel_sample = z_sample;
            default: sel_sample = 12'h000;
        endcase

        if (csb_s) begin
            state_d      = ST_IDLE;
            busy_d       = 1'b0;
            dout_d       = 1'b0;
            bit_cnt_d    = 3'd0;
            busy_phase_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dout_d = 1'b0;
                    busy_d = 1'b0;
                    if (rise && din_s) begin
                        shift_d   = 8'h01;
                        bit_cnt_d = 3'd1;
                        state_d   = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (rise) begin
                        shift_d = cmd_next;
                        if (bit_cnt_q == 3'd7) begin
                            // Shadow copy makes the frame immune to later sample changes
                            last_cmd_d   = cmd_next;
                            shadow_d     = sel_sample;
                            remaining_d  = cmd_next[3] ? 4'd7 : 4'd11;
                            busy_phase_d = 1'b0;
                            state_d      = ST_BUSY;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (fall) begin
                        if (!busy_phase_q) begin
                            busy_d       = 1'b1;
                            busy_phase_d = 1'b1;
                        end else begin
                            busy_d   = 1'b0;
                            dout_d   = shadow_q[11];
                            shadow_d = {shadow_q[10:0], 1'b0};
                            state_d  = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (fall) begin
                        if (remaining_q != 4'd0) begin
                            dout_d      = shadow_q[11];
                            shadow_d    = {shadow_q[10:0], 1'b0};
                            remaining_d = remaining_q - 4'd1;
                        end else begin
                            dout_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            clk_sync_q   <= 3'b000;
            csb_sync_q   <= 2'b00;
            din_sync_q   <= 2'b00;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            shadow_q     <= 12'h000;
            remaining_q  <= 4'd0;
            busy_phase_q <= 1'b0;
            busy_q       <= 1'b0;
            dout_q       <= 1'b0;
            last_cmd_q   <= 8'h00;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_sync_q   <= clk_sync_d;
            csb_sync_q   <= csb_sync_d;
            din_sync_q   <= din_sync_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            shadow_q     <= shadow_d;
            remaining_q  <= remaining_d;
            busy_phase_q <= busy_phase_d;
            busy_q       <= busy_d;
            dout_q       <= dout_d;
            last_cmd_q   <= last_cmd_d;
            done_q       <= done_d;
        end
    end

    assign touch_busy = busy_q;
    assign touch_dout = dout_q;
    assign last_cmd   = last_cmd_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_touch_adc_responder.sv
// tb/tb_touch_adc_responder.sv - randomized frame-level checks of touch_adc_responder against a protocol model
module tb_touch_adc_responder;

    logic        cclk = 1'b0;
    logic        rst;
    logic        touch_clk;
    logic        touch_csb;
    logic        touch_din;
    logic [11:0] x_sample;
    logic [11:0] y_sample;
    logic [11:0] z_sample;
    logic        touch_busy;
    logic        touch_dout;
    logic [7:0]  last_cmd;
    logic        frame_done;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   wide_cnt = 0;
    logic done_prev = 1'b0;

    touch_adc_responder dut (
        .cclk       (cclk),
        .rst        (rst),
        .touch_clk  (touch_clk),
        .touch_csb  (touch_csb),
        .touch_din  (touch_din),
        .x_sample   (x_sample),
        .y_sample   (y_sample),
        .z_sample   (z_sample),
        .touch_busy (touch_busy),
        .touch_dout (touch_dout),
        .last_cmd   (last_cmd),
        .frame_done (frame_done)
    );

    always #5 cclk = ~cclk;

    always @(negedge cclk) begin
        if (frame_done) done_cnt++;
        if (frame_done && done_prev) wide_cnt++;
        done_prev = frame_done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge cclk);
        #1;
    endtask

    function automatic logic [11:0] model(input logic [7:0] cmd, input logic [11:0] x,
                                          input logic [11:0] y, input logic [11:0] z);
        logic [11:0] v;
        case (cmd[6:4])
            3'b101:  v = x;
            3'b001:  v = y;
            3'b011:  v = z;
            default: v = 12'h000;
        endcase
        return cmd[3] ? {4'h0, v[11:4]} : v;
    endfunction

    task automatic randomize_samples();
        x_sample = 12'($urandom);
        y_sample = 12'($urandom);
        z_sample = 12'($urandom);
    endtask

    // mode 0: full frame, 1: csb abort after 5 data bits, 2: reset while BUSY is high
    task automatic frame(input int nz, input logic [7:0] cmd, input int half, input int mode);
        int          len, total, rs, busy_hi, d0;
        logic [11:0] exp, rx;
        len     = cmd[3] ? 8 : 12;
        exp     = model(cmd, x_sample, y_sample, z_sample);
        total   = nz + 9 + len;
        busy_hi = 0;
        rx      = 12'h000;
        d0      = done_cnt;
        touch_clk = 1'b0;
        touch_csb = 1'b0;
        wait_cyc(half);
        for (int r = 1; r <= total; r++) begin
            rs = r - nz;
            if (r <= nz)      touch_din = 1'b0;
            else if (rs <= 8) touch_din = cmd[8 - rs];
            else              touch_din = 1'($urandom_range(0, 1));
            wait_cyc(half);
            if (touch_busy) busy_hi++;
            if (rs == 9) check("busy_at_r9", touch_busy, 1);
            if (rs >= 10) rx = {rx[10:0], touch_dout};
            if (mode == 2 && rs == 9) begin
                rst       = 1'b1;
                touch_csb = 1'b1;
                touch_din = 1'b0;
                wait_cyc(1);
                check("rst_busy", touch_busy, 0);
                check("rst_dout", touch_dout, 0);
                check("rst_last_cmd", last_cmd, 8'h00);
                check("rst_no_done", done_cnt - d0, 0);
                wait_cyc(2);
                rst       = 1'b0;
                touch_clk = 1'b0;
                wait_cyc(half);
                return;
            end
            touch_clk = 1'b1;
            if (rs == 10) randomize_samples();
            wait_cyc(half);
            if (mode == 1 && rs == 14) begin
                check("abort_pre_dout", touch_dout, 1);
                touch_csb = 1'b1;
                wait_cyc(4);
                check("abort_dout", touch_dout, 0);
                check("abort_busy", touch_busy, 0);
                touch_clk = 1'b0;
                wait_cyc(2 * half);
                check("abort_no_done", done_cnt - d0, 0);
                check("abort_dout_late", touch_dout, 0);
                return;
            end
            touch_clk = 1'b0;
        end
        wait_cyc(half);
        check("dout_after_frame", touch_dout, 0);
        check("busy_dclk_count", busy_hi, 1);
        check("rx_data", rx, exp);
        check("last_cmd", last_cmd, cmd);
        check("frame_done_count", done_cnt - d0, 1);
        touch_csb = 1'b1;
        wait_cyc(half);
    endtask

    initial begin
        rst       = 1'b1;
        touch_clk = 1'b0;
        touch_csb = 1'b1;
        touch_din = 1'b0;
        x_sample  = 12'h000;
        y_sample  = 12'h000;
        z_sample  = 12'h000;
        wait_cyc(3);
        check("reset_busy", touch_busy, 0);
        check("reset_dout", touch_dout, 0);
        check("reset_last_cmd", last_cmd, 8'h00);
        check("reset_done", frame_done, 0);
        rst = 1'b0;
        wait_cyc(5);

        x_sample = 12'hA5C;
        frame(0, 8'hD0, 25, 0);
        y_sample = 12'h3F7;
        frame(0, 8'h98, 25, 0);
        z_sample = 12'h6B1;
        frame(3, 8'hB0, 25, 0);
        randomize_samples();
        frame(0, 8'h80, 12, 0);
        x_sample = 12'hFFF;
        frame(0, 8'hD0, 25, 1);
        x_sample = 12'hA5C;
        frame(0, 8'hD0, 25, 0);
        frame(1, 8'hD0, 10, 2);
        y_sample = 12'h3F7;
        frame(0, 8'h98, 10, 0);

        for (int i = 0; i < 20; i++) begin
            randomize_samples();
            frame(int'($urandom_range(0, 3)), 8'($urandom) | 8'h80, int'($urandom_range(6, 25)), 0);
        end

        check("frame_done_width", wide_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/touch_adc_responder.md
# touch_adc_responder

Cycle-level behavioural model of the resistive-touch ADC (ADS7843-style) on the serial side of the touchpad link. It responds to the touch controller's DCLK/CS/DIN traffic and drives BUSY and DOUT back. It sits in the bench and emulation top-levels in place of the physical touch chip. X/Y/Z conversion values come from parallel inputs, so touch coordinates are fully controllable.

## Interface
- No parameters.
- `cclk` in 1: system clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `touch_clk` in 1: DCLK from the controller. Asynchronous to `cclk`; oversampled.
- `touch_csb` in 1: chip select, active low.
- `touch_din` in 1: serial command from the controller (its `data_out`).
- `x_sample` in 12: X conversion value.
- `y_sample` in 12: Y conversion value.
- `z_sample` in 12: Z conversion value.
- `touch_busy` out 1: BUSY to the controller.
- `touch_dout` out 1: serial result to the controller (its `data_in`).
- `last_cmd` out 8: most recent complete control byte.
- `frame_done` out 1: one-`cclk` pulse when a result frame finishes.

## Operation
- **Input synchronisation:** `touch_clk`, `touch_csb` and `touch_din` each pass through a 2-flop synchroniser.
  - A third flop on DCLK gives `rise` = sync & ~prev and `fall` = ~sync & prev.
  - Only synchronised values are used.
- **Control byte:** MSB first, sampled on `rise`. Bit order: S, A2, A1, A0, MODE, SER/DFR, PD1, PD0.
  - SER/DFR and PD bits are captured into `last_cmd` but are otherwise ignored.
- **Channel select (A2..A0):**
  - 101 → X
  - 001 → Y
  - 011 → Z
  - Any other code → 12'h000
- **MODE:** 0 = 12-bit result. 1 = 8-bit result (top 8 bits of the value).
- **State machine:**
  - **IDLE:** `touch_dout` = 0, `touch_busy` = 0. On `rise` with csb low and din = 1 (start bit), load shift reg bit 7, set bit count 1, go to CMD. Leading zeros while csb is low are ignored.
  - **CMD:** shift din on each `rise`. On the `rise` that completes bit 8:
    - update `last_cmd`;
    - latch the selected sample into a 12-bit shadow register (frame data is immune to later sample changes);
    - set the data length to 12 or 8;
    - go to BUSY.
  - **BUSY:** on the first `fall`, `touch_busy` ← 1. On the next `fall`, `touch_busy` ← 0, `touch_dout` ← shadow[11], remaining = length−1, go to DATA.
  - **DATA:**
    - On each `fall`, if remaining > 0, drive the next lower shadow bit and decrement.
    - If remaining = 0, `touch_dout` ← 0, pulse `frame_done`, go to IDLE.
- **Chip select:** csb high (synchronised) in any state forces IDLE on the next `cclk`. It also clears `touch_busy` and `touch_dout`. `last_cmd` is kept, and `frame_done` does not pulse.
- **Simultaneous events:** csb-high takes priority over `rise` and `fall` in the same cycle.
- **Invalid start:** a start bit seen while not in IDLE is ignored; command/data overlap is not supported.
- **Reset values:**
  - state = IDLE
  - `touch_busy` = 0, `touch_dout` = 0
  - `last_cmd` = 8'h00, `frame_done` = 0
  - counters and shadow = 0
  - Reset mid-frame aborts immediately.

## Timing
- Sampling: input → edge detect takes 3 `cclk` (2 sync + 1 edge flop). Outputs are registered, so `touch_dout`/`touch_busy` change 4 `cclk` after the physical DCLK falling edge.
- DCLK half-period must be ≥ 6 `cclk`; the standard 25-`cclk` divider is well inside this.
- The controller samples DOUT on DCLK rising edges; DOUT is stable a full half-period beforehand.
- Frame, counted in DCLK rising edges from the start bit (rising 1):
  - rising 1–8: command;
  - BUSY high from the falling edge after rising 8 to the falling edge after rising 9;
  - MSB valid for rising 10;
  - 12-bit LSB valid for rising 21 (8-bit: rising 17);
  - DOUT returns to 0 at the next falling edge, where `frame_done` pulses.
- `frame_done` is high for exactly one `cclk`.

## Test plan
- **X read:** `x_sample` = 12'hA5C, command 8'hD0 at a 25-`cclk` half-period → BUSY high for exactly one DCLK, the controller receives 12'hA5C, `last_cmd` = 8'hD0, `frame_done` pulses once.
- **Y read, 8-bit:** `y_sample` = 12'h3F7, command 8'h98 → bits received on rising 10–17 = 8'h3F, then DOUT = 0.
- **Z read with leading zeros:** three zero bits with csb low, then 8'hB0 → `z_sample` is returned. Changing `z_sample` mid-frame has no effect on the frame.
- **Invalid channel:** command 8'h80 (A = 000) → 12'h000 returned, BUSY still pulses.
- **csb abort:** raise csb after 5 data bits → within 3 `cclk` of the synchronised edge, state is IDLE, DOUT = 0, BUSY = 0, no `frame_done`. The next full 8'hD0 frame is correct.
- **Reset mid-BUSY:** assert `rst` while `touch_busy` = 1 → next `cclk` all outputs are 0, `last_cmd` = 8'h00. The following frame is correct.
